data_sync_ctrl: RTL
===================

DATA_SYNC_CTRL -- requirements
Module: data_sync_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, width of the data bus crossing into the CLK domain.
REQ-002 SHALL have parameter NUM_STAGES, default 2, number of synchroniser flops on BUS_ENABLE; legal range 2..8.
REQ-003 SHALL have parameter TOGGLE_MODE, default 0: 0 = a rising edge of BUS_ENABLE marks new data; 1 = any level change marks new data.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of the event counter.
REQ-005 SHALL have port CLK  input  1  destination-domain clock, rising-edge active.
REQ-006 SHALL have port RST  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have port UNSYNC_BUS  input  BUS_WIDTH  source-domain data; held stable by the sender from before the BUS_ENABLE event until after ENABLE_PULSE.
REQ-008 SHALL have port BUS_ENABLE  input  1  source-domain qualifier, asynchronous to CLK.
REQ-009 SHALL have port SYNC_BUS  output  BUS_WIDTH  captured data, registered.
REQ-010 SHALL have port ENABLE_PULSE  output  1  one-cycle strobe, registered; SYNC_BUS updates in the same cycle.
REQ-011 SHALL have port EVT_CNT  output  CNT_WIDTH  count of accepted events, registered.

Function
REQ-012 SHALL pass BUS_ENABLE through a NUM_STAGES flop chain; the chain output is en_sync.
REQ-013 SHALL register en_sync into en_prev every cycle.
REQ-014 SHALL define event = en_sync AND NOT en_prev when TOGGLE_MODE=0, and event = en_sync XOR en_prev when TOGGLE_MODE=1.
REQ-015 On a clock edge with event=1: SYNC_BUS <= UNSYNC_BUS, ENABLE_PULSE <= 1, EVT_CNT <= EVT_CNT+1.
REQ-016 On a clock edge with event=0: SYNC_BUS holds, ENABLE_PULSE <= 0, EVT_CNT holds.
REQ-017 UNSYNC_BUS SHALL never pass through the multi-flop chain; it SHALL be sampled only through the event-gated capture register (mux recirculation).
REQ-018 Latency: for a BUS_ENABLE transition sampled at edge k, ENABLE_PULSE and the new SYNC_BUS SHALL appear after edge k+NUM_STAGES; ENABLE_PULSE SHALL drop after edge k+NUM_STAGES+1.
REQ-019 ENABLE_PULSE SHALL be exactly one cycle wide per event, regardless of how long BUS_ENABLE stays high.
REQ-020 Back-to-back: events on consecutive cycles (TOGGLE_MODE=1 only) SHALL each produce a pulse, a capture and an increment; the pulse stays high across both cycles.
REQ-021 EVT_CNT SHALL wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-022 Mode 0: a BUS_ENABLE high pulse shorter than one CLK period may be lost; the sender guarantees each level lasts at least 2 CLK periods.
REQ-023 Mode 1: the sender guarantees at least 2 CLK periods between toggles.

Reset
REQ-024 While RST=0: sync chain, en_prev, SYNC_BUS, ENABLE_PULSE and EVT_CNT SHALL all be 0.
REQ-025 After reset release with BUS_ENABLE held at 1: one event SHALL be produced, NUM_STAGES+1 edges later, in both modes (reference level after reset is 0).
REQ-026 Reset asserted mid-event (chain partly filled) SHALL clear all state immediately; no pulse SHALL be produced for that event after release unless REQ-025 applies.

Structure
REQ-027 Package data_sync_pkg SHALL hold the default parameter values and the NUM_STAGES legal-range constants.
REQ-028 The flop chain SHALL be a sub-module sync_stage_chain (parameter NUM_STAGES, 1-bit in/out, CLK/RST), instantiated once.
REQ-029 An elaboration check SHALL reject NUM_STAGES outside 2..8.

Verification (NUM_STAGES=2, BUS_WIDTH=8, CNT_WIDTH=8 unless noted)
REQ-030 Mode 0, UNSYNC_BUS=0xA5, BUS_ENABLE 0->1 at edge 0 and held 10 cycles -> SYNC_BUS=0xA5 with ENABLE_PULSE=1 after edge 2 only; EVT_CNT=1.
REQ-031 Mode 1, BUS_ENABLE toggled every 3 cycles with data 0x11, 0x22, 0x33 -> three single-cycle pulses, SYNC_BUS sequence 0x11/0x22/0x33, EVT_CNT=3; the falling toggle counts.
REQ-032 Mode 0, 256 enable pulses -> EVT_CNT wraps to 0; SYNC_BUS equals the last data word.
REQ-033 RST low while BUS_ENABLE=1 and 1 cycle after its rise -> outputs 0; after release, exactly one pulse at edge NUM_STAGES+1.
REQ-034 NUM_STAGES=4, single rising edge -> pulse after edge 4; UNSYNC_BUS changes while no event is active -> SYNC_BUS unchanged.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared defaults and legal-range limits for the data_sync_ctrl CDC capture block.
package data_sync_pkg;

  localparam int unsigned DEF_BUS_WIDTH   = 8;
  localparam int unsigned DEF_NUM_STAGES  = 2;
  localparam int unsigned DEF_TOGGLE_MODE = 0;
  localparam int unsigned DEF_CNT_WIDTH   = 8;

  localparam int unsigned MIN_NUM_STAGES  = 2;
  localparam int unsigned MAX_NUM_STAGES  = 8;

endpackage : data_sync_pkg

// File: rtl/sync_stage_chain.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module sync_stage_chain
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic [NUM_STAGES-1:0] stages;

  // Plain shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stages <= '0;
    end else begin
      stages <= {stages[NUM_STAGES-2:0], din};
    end
  end

  assign dout = stages[NUM_STAGES-1];

endmodule : sync_stage_chain

// File: rtl/data_sync_ctrl.sv
// Captures a source-domain data bus into CLK domain, qualified by a synchronised
// BUS_ENABLE edge; the data itself is only ever sampled by the gated capture register.
module data_sync_ctrl
  import data_sync_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned TOGGLE_MODE = DEF_TOGGLE_MODE,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic [CNT_WIDTH-1:0] EVT_CNT
);

  if ((NUM_STAGES < MIN_NUM_STAGES) || (NUM_STAGES > MAX_NUM_STAGES)) begin : g_bad_stages
    $error("data_sync_ctrl: NUM_STAGES=%0d outside legal range %0d..%0d",
           NUM_STAGES, MIN_NUM_STAGES, MAX_NUM_STAGES);
  end

  localparam bit ANY_EDGE = (TOGGLE_MODE != 0);

  logic en_sync;
  logic en_prev;
  logic evt_c;

  sync_stage_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync_stage_chain (
    .CLK  (CLK),
    .RST  (RST),
    .din  (BUS_ENABLE),
    .dout (en_sync)
  );

  // en_prev resets to 0, so a level already high at release reads as a fresh edge.
  assign evt_c = ANY_EDGE ? (en_sync ^ en_prev) : (en_sync & ~en_prev);

  // Capture register recirculates unless an event is present.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_prev      <= 1'b0;
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
      EVT_CNT      <= '0;
    end else begin
      en_prev      <= en_sync;
      ENABLE_PULSE <= evt_c;
      if (evt_c) begin
        SYNC_BUS <= UNSYNC_BUS;
        EVT_CNT  <= EVT_CNT + CNT_WIDTH'(1);
      end
    end
  end

endmodule : data_sync_ctrl
